// File: rtl/i2c_cfg_sequencer_if.sv
// Host, i2c_master request/response and status signals of i2c_cfg_sequencer.
// With I2C_SEQ_READBACK_EN defined, the readback port pair rb_addr/rb_data is added.
interface i2c_cfg_sequencer_if #(
    parameter int DEPTH = 16
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [43:0]       cfg_data;
    logic [ADDR_W:0]   num_cmds;
    logic              start;

    logic              rv0_valid;
    logic              rv0_ready;
    logic [6:0]        rv0_slave_address;
    logic [1:0]        rv0_burst_count_wr;
    logic [1:0]        rv0_burst_count_rd;
    logic              rv0_rd_wrn;
    logic [31:0]       rv0_wdata;

    logic              rv1_valid;
    logic              rv1_ready;
    logic              rv1_nack;
    logic [31:0]       rv1_rdata;

    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] fail_index;
    logic [31:0]       rdata;

`ifdef I2C_SEQ_READBACK_EN
    logic [ADDR_W-1:0] rb_addr;
    logic [31:0]       rb_data;

    modport master (
        input  cfg_we, cfg_addr, cfg_data, num_cmds, start,
        input  rv0_ready, rv1_valid, rv1_nack, rv1_rdata, rb_addr,
        output rv0_valid, rv0_slave_address, rv0_burst_count_wr, rv0_burst_count_rd,
        output rv0_rd_wrn, rv0_wdata, rv1_ready, busy, done, error, fail_index, rdata, rb_data
    );
    modport slave (
        output cfg_we, cfg_addr, cfg_data, num_cmds, start,
        output rv0_ready, rv1_valid, rv1_nack, rv1_rdata, rb_addr,
        input  rv0_valid, rv0_slave_address, rv0_burst_count_wr, rv0_burst_count_rd,
        input  rv0_rd_wrn, rv0_wdata, rv1_ready, busy, done, error, fail_index, rdata, rb_data
    );
`else
    modport master (
        input  cfg_we, cfg_addr, cfg_data, num_cmds, start,
        input  rv0_ready, rv1_valid, rv1_nack, rv1_rdata,
        output rv0_valid, rv0_slave_address, rv0_burst_count_wr, rv0_burst_count_rd,
        output rv0_rd_wrn, rv0_wdata, rv1_ready, busy, done, error, fail_index, rdata
    );
    modport slave (
        output cfg_we, cfg_addr, cfg_data, num_cmds, start,
        output rv0_ready, rv1_valid, rv1_nack, rv1_rdata,
        input  rv0_valid, rv0_slave_address, rv0_burst_count_wr, rv0_burst_count_rd,
        input  rv0_rd_wrn, rv0_wdata, rv1_ready, busy, done, error, fail_index, rdata
    );
`endif
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Replays a host-loaded table of I2C commands into i2c_master, retrying NACKed commands.
// Optional I2C_SEQ_READBACK_EN keeps every successful read result in a readback RAM.
module i2c_cfg_sequencer #(
    parameter int DEPTH       = 16,
    parameter int MAX_RETRIES = 3,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    i2c_cfg_sequencer_if.master   bus
);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W:0]    DEPTH_N   = (ADDR_W + 1)'(DEPTH);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [43:0]         table_mem [DEPTH];
    logic [43:0]         req;
    logic [ADDR_W:0]     idx;
    logic [ADDR_W:0]     num;
    logic [RETRY_W-1:0]  retry;
    logic [GAP_W-1:0]    gap_cnt;
    logic                error_q;
    logic [ADDR_W-1:0]   fail_q;
    logic [31:0]         rdata_q;
    logic                start_ok;
    logic                resp_fire;
    logic                retry_left;

    function automatic logic [ADDR_W:0] clamp_num(input logic [ADDR_W:0] n);
        return (n > DEPTH_N) ? DEPTH_N : n;
    endfunction

    assign start_ok   = (state == S_IDLE) && bus.start;
    assign resp_fire  = (state == S_WAIT) && bus.rv1_valid;
    assign retry_left = (retry < RETRY_MAX);

    // Host writes only land while idle; a write coinciding with start lands before LOAD reads it.
    always_ff @(posedge i_clk) begin
        if (bus.cfg_we && (state == S_IDLE)) begin
            table_mem[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.rv0_valid = 1'b0;
        bus.rv1_ready = 1'b0;
        bus.done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.num_cmds == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                bus.rv0_valid = 1'b1;
                if (bus.rv0_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.rv1_ready = 1'b1;
                if (bus.rv1_valid) begin
                    state_nxt = (!bus.rv1_nack || retry_left) ? S_GAP : S_ERR;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = (idx == num) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req     <= '0;
            idx     <= '0;
            num     <= '0;
            retry   <= '0;
            gap_cnt <= '0;
            error_q <= 1'b0;
            fail_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (start_ok) begin
                idx     <= '0;
                retry   <= '0;
                num     <= clamp_num(bus.num_cmds);
                error_q <= 1'b0;
            end
            if (state == S_LOAD) begin
                req <= table_mem[idx[ADDR_W-1:0]];
            end
            // Gap counter restarts every time the FSM enters GAP.
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (resp_fire) begin
                if (!bus.rv1_nack) begin
                    retry <= '0;
                    idx   <= idx + 1'b1;
                    if (req[32]) begin
                        rdata_q <= bus.rv1_rdata;
                    end
                end else if (retry_left) begin
                    retry <= retry + 1'b1;
                end else begin
                    error_q <= 1'b1;
                    fail_q  <= idx[ADDR_W-1:0];
                end
            end
        end
    end

    assign bus.rv0_slave_address  = req[43:37];
    assign bus.rv0_burst_count_wr = req[36:35];
    assign bus.rv0_burst_count_rd = req[34:33];
    assign bus.rv0_rd_wrn         = req[32];
    assign bus.rv0_wdata          = req[31:0];
    assign bus.busy               = (state != S_IDLE);
    assign bus.error              = error_q;
    assign bus.fail_index         = fail_q;
    assign bus.rdata              = rdata_q;

`ifdef I2C_SEQ_READBACK_EN
    logic [31:0] rb_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst && resp_fire && !bus.rv1_nack && req[32]) begin
            rb_mem[idx[ADDR_W-1:0]] <= bus.rv1_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.rb_data <= '0;
        end else begin
            bus.rb_data <= rb_mem[bus.rb_addr];
        end
    end
`endif
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: table-driven scenarios, reset corner cases and random runs
// against an attempt-level reference model of the command sequence.
module tb_i2c_cfg_sequencer;
    localparam int DEPTH       = 16;
    localparam int MAX_RETRIES = 3;
    localparam int GAP_CYCLES  = 8;
    localparam int ADDR_W      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_cfg_sequencer_if #(.DEPTH(DEPTH)) bus ();

    i2c_cfg_sequencer #(
        .DEPTH(DEPTH), .MAX_RETRIES(MAX_RETRIES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [43:0] tbl       [DEPTH];
    logic [31:0] cmd_rdata [DEPTH];
    int          nacks     [DEPTH];
    logic [31:0] rb_model  [DEPTH];
    bit          rb_vld    [DEPTH];
    logic [31:0] exp_rdata;

    typedef struct {
        int          num;
        logic [15:0] nk;        // NACK count per command, one nibble each for cmds 0..3
        int          rdly;
        int          sdly;
        bit          wr_busy;
        bit          wr_start;
        bit          poke;
        int          exp_iss;
        bit          exp_err;
    } vec_t;

    function automatic void check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [43:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = ADDR_W'(a);
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
        tbl[a]       = d;
    endtask

    function automatic logic [43:0] rand_entry();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[43:0];
    endfunction

    task automatic run_seq(input int num, input int rdly, input int sdly, input bit wr_busy,
                           input bit wr_start, input bit poke, input string tag,
                           output int n_iss, output bit err_out);
        logic [43:0] exp_iss[$];
        logic [43:0] got_iss[$];
        logic [32:0] resp[$];
        logic [43:0] cur, held;
        logic [32:0] r;
        logic [31:0] junk;
        int          num_eff, exp_fail, done_cnt, done_cyc, wait_cnt, resp_wait;
        bit          exp_err, in_req, pend, stable_ok, finished, iss_ok, nk;

        if (wr_start) tbl[0] = {tbl[0][43:32], tbl[0][31:0] + 32'h1};

        // Reference model: each command is attempted until ACKed or MAX_RETRIES re-issues are used.
        num_eff  = (num > DEPTH) ? DEPTH : num;
        exp_err  = 1'b0;
        exp_fail = 0;
        for (int i = 0; i < num_eff && !exp_err; i++) begin
            for (int k = 0; k <= MAX_RETRIES; k++) begin
                nk   = (k < nacks[i]);
                junk = $urandom;
                exp_iss.push_back(tbl[i]);
                resp.push_back(nk ? {1'b1, junk} : {1'b0, cmd_rdata[i]});
                if (!nk) begin
                    if (tbl[i][32]) begin
                        exp_rdata   = cmd_rdata[i];
                        rb_model[i] = cmd_rdata[i];
                        rb_vld[i]   = 1'b1;
                    end
                    break;
                end
                if (k == MAX_RETRIES) begin
                    exp_err  = 1'b1;
                    exp_fail = i;
                end
            end
        end

        bus.num_cmds = (ADDR_W + 1)'(num);
        bus.start    = 1'b1;
        if (wr_start) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = '0;
            bus.cfg_data = tbl[0];
        end
        done_cnt = 0; done_cyc = -1; wait_cnt = 0; resp_wait = 0;
        in_req = 1'b0; pend = 1'b0; stable_ok = 1'b1; finished = 1'b0;
        held = '0;
        for (int cyc = 1; cyc <= 20000 && !finished; cyc++) begin
            tick();
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
            if (cyc == 1) check_eq({tag, "_err_clr"}, bus.error, 0);
            if (wr_busy && cyc == 2 && bus.busy) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = '0;
                bus.cfg_data = ~tbl[0];
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (poke) bus.start = 1'b1;
            end
            cur = {bus.rv0_slave_address, bus.rv0_burst_count_wr, bus.rv0_burst_count_rd,
                   bus.rv0_rd_wrn, bus.rv0_wdata};
            bus.rv0_ready = 1'b0;
            if (bus.rv0_valid) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    held     = cur;
                    wait_cnt = 0;
                end else if (cur !== held) begin
                    stable_ok = 1'b0;
                end
                if (wait_cnt >= rdly) begin
                    bus.rv0_ready = 1'b1;
                    got_iss.push_back(cur);
                    in_req    = 1'b0;
                    pend      = 1'b1;
                    resp_wait = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (in_req) begin
                stable_ok = 1'b0;
            end
            bus.rv1_valid = 1'b0;
            bus.rv1_nack  = 1'b0;
            bus.rv1_rdata = $urandom;
            if (pend && bus.rv1_ready && resp_wait >= sdly) begin
                r = (resp.size() > 0) ? resp.pop_front() : {1'b0, 32'hDEAD_BEEF};
                {bus.rv1_nack, bus.rv1_rdata} = r;
                bus.rv1_valid = 1'b1;
                pend = 1'b0;
            end else if (pend && bus.rv1_ready) begin
                resp_wait++;
            end else if (!bus.rv1_ready) begin
                // Stray responses while not waiting must be ignored by the sequencer.
                bus.rv1_valid = 1'($urandom_range(0, 1));
                bus.rv1_nack  = 1'($urandom_range(0, 1));
            end
            if (!bus.busy) finished = 1'b1;
        end
        bus.rv0_ready = 1'b0;
        bus.rv1_valid = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_we    = 1'b0;
        check_eq({tag, "_finished"}, finished, 1);

        if (poke) begin
            tick();
            tick();
            check_eq({tag, "_start_in_done_ignored"}, bus.busy, 0);
        end

        n_iss  = got_iss.size();
        iss_ok = (got_iss.size() == exp_iss.size());
        for (int i = 0; i < got_iss.size() && i < exp_iss.size(); i++) begin
            if (got_iss[i] !== exp_iss[i]) begin
                iss_ok = 1'b0;
                $display("FAIL %s_issue%0d: got 0x%0h, expected 0x%0h", tag, i, got_iss[i], exp_iss[i]);
            end
        end
        check_eq({tag, "_issue_count"}, n_iss, exp_iss.size());
        check_eq({tag, "_issue_fields"}, iss_ok, 1);
        check_eq({tag, "_stable"}, stable_ok, 1);
        check_eq({tag, "_done_count"}, done_cnt, exp_err ? 0 : 1);
        check_eq({tag, "_error"}, bus.error, exp_err);
        if (exp_err) check_eq({tag, "_fail_index"}, bus.fail_index, exp_fail);
        check_eq({tag, "_rdata"}, bus.rdata, exp_rdata);
        if (num_eff == 0) check_eq({tag, "_done_latency"}, done_cyc, 1);
`ifdef I2C_SEQ_READBACK_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (rb_vld[i]) begin
                bus.rb_addr = ADDR_W'(i);
                tick();
                check_eq($sformatf("%s_rb%0d", tag, i), bus.rb_data, rb_model[i]);
            end
        end
`endif
        err_out = bus.error;
    endtask

    initial begin
        vec_t        vecs[8];
        int          n_iss;
        bit          err;
        bit          seen;
        string       tag;

        vecs[0] = '{3,  16'h0000, 0,  0, 1'b1, 1'b0, 1'b0, 3,  1'b0};
        vecs[1] = '{0,  16'h0000, 0,  0, 1'b0, 1'b0, 1'b1, 0,  1'b0};
        vecs[2] = '{3,  16'h0020, 0,  0, 1'b0, 1'b1, 1'b0, 5,  1'b0};
        vecs[3] = '{3,  16'h0900, 0,  1, 1'b0, 1'b0, 1'b0, 6,  1'b1};
        vecs[4] = '{4,  16'h0000, 50, 0, 1'b1, 1'b0, 1'b0, 4,  1'b0};
        vecs[5] = '{1,  16'h0003, 0,  2, 1'b0, 1'b0, 1'b1, 4,  1'b0};
        vecs[6] = '{1,  16'h0004, 1,  0, 1'b0, 1'b0, 1'b0, 4,  1'b1};
        vecs[7] = '{20, 16'h0000, 1,  2, 1'b0, 1'b0, 1'b0, 16, 1'b0};

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.num_cmds = '0;
        bus.start = 1'b0; bus.rv0_ready = 1'b0; bus.rv1_valid = 1'b0; bus.rv1_nack = 1'b0;
        bus.rv1_rdata = '0;
`ifdef I2C_SEQ_READBACK_EN
        bus.rb_addr = '0;
`endif
        for (int i = 0; i < DEPTH; i++) rb_vld[i] = 1'b0;
        exp_rdata = '0;

        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_error", bus.error, 0);
        check_eq("rst_rv0_valid", bus.rv0_valid, 0);
        check_eq("rst_rv1_ready", bus.rv1_ready, 0);
        check_eq("rst_fields", {bus.rv0_slave_address, bus.rv0_burst_count_wr, bus.rv0_burst_count_rd,
                                bus.rv0_rd_wrn, bus.rv0_wdata}, 0);
        check_eq("rst_fail_rdata", {bus.fail_index, bus.rdata}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            write_entry(i, rand_entry());
            cmd_rdata[i] = $urandom;
        end
        write_entry(0, {7'h74, 2'd0, 2'd0, 1'b0, 32'h0000_0001});
        write_entry(1, {7'h5D, 2'd0, 2'd0, 1'b0, 32'h0000_0011});
        write_entry(2, {7'h5D, 2'd0, 2'd0, 1'b0, 32'h0000_0022});
        write_entry(3, {7'h5D, 2'd0, 2'd1, 1'b1, 32'h0000_0000});
        cmd_rdata[3] = 32'hA5B6_C7D8;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < DEPTH; i++) nacks[i] = (i < 4) ? int'(vecs[v].nk[i*4 +: 4]) : 0;
            tag = $sformatf("vec%0d", v);
            run_seq(vecs[v].num, vecs[v].rdly, vecs[v].sdly, vecs[v].wr_busy, vecs[v].wr_start,
                    vecs[v].poke, tag, n_iss, err);
            check_eq({tag, "_tbl_issues"}, n_iss, vecs[v].exp_iss);
            check_eq({tag, "_tbl_error"}, err, vecs[v].exp_err);
            if (v == 4) check_eq("vec4_read_A5B6C7D8", bus.rdata, 32'hA5B6_C7D8);
            repeat (2) tick();
        end

        // Reset while waiting for a response clears every output on the next cycle.
        for (int i = 0; i < DEPTH; i++) nacks[i] = 0;
        bus.num_cmds = 5'd1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (bus.rv0_valid) begin
                bus.rv0_ready = 1'b1;
                seen = 1'b1;
            end
            tick();
        end
        bus.rv0_ready = 1'b0;
        check_eq("rstw_in_wait", bus.rv1_ready, 1);
        rst = 1'b1;
        tick();
        check_eq("rstw_ctrl", {bus.busy, bus.done, bus.error, bus.rv0_valid, bus.rv1_ready, bus.fail_index}, 0);
        check_eq("rstw_fields", {bus.rv0_slave_address, bus.rv0_burst_count_wr, bus.rv0_burst_count_rd,
                                 bus.rv0_rd_wrn, bus.rv0_wdata}, 0);
        check_eq("rstw_rdata", bus.rdata, 0);
        rst = 1'b0;
        exp_rdata = '0;
        tick();

        for (int t = 0; t < 12; t++) begin
            for (int w = 0; w < 4; w++) write_entry($urandom_range(0, DEPTH - 1), rand_entry());
            for (int i = 0; i < DEPTH; i++) begin
                cmd_rdata[i] = $urandom;
                nacks[i]     = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
            end
            run_seq($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", t), n_iss, err);
            repeat (2) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
